// File: rtl/rr_req_queue.sv
// rr_req_queue: request front-end for a 4-way round-robin arbiter.
//
// Each of the four clients owns a private FIFO of DEPTH x DATA_W words.
// req[3:0] is derived from FIFO occupancy. The arbiter's registered grant[3:0]
// pops the granted FIFO, and the popped word is presented with its client ID
// on a registered, one-cycle out_valid pulse. There is no output backpressure.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   push       - push[i] writes client i's word into FIFO i
//   push_data  - packed client words; client i at [i*DATA_W +: DATA_W]
//   full       - full[i] is high when FIFO i holds DEPTH entries
//   req        - request vector to the arbiter (combinational)
//   grant      - grant vector from the arbiter (registered, one-hot or zero)
//   out_valid  - one-cycle pulse, one word delivered
//   out_data   - popped word (holds when out_valid is low)
//   out_id     - client index of out_data (holds when out_valid is low)
//   err_grant  - sticky flag: grant to an empty FIFO, or multi-bit grant
//
// Optional feature, macro RRQ_STATS_EN:
//   stats_clr  - synchronously zeroes all pop counters (wins over a pop)
//   grant_cnt  - four 16-bit saturating counts of successful pops,
//                client i at [i*16 +: 16]
module rr_req_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            push,
  input  logic [4*DATA_W-1:0]   push_data,
  output logic [3:0]            full,
  output logic [3:0]            req,
  input  logic [3:0]            grant,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_id,
  output logic                  err_grant
`ifdef RRQ_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [4*16-1:0]       grant_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q [4][DEPTH];

  logic [PtrW-1:0] wr_ptr_q [4];
  logic [PtrW-1:0] wr_ptr_d [4];
  logic [PtrW-1:0] rd_ptr_q [4];
  logic [PtrW-1:0] rd_ptr_d [4];
  logic [CntW-1:0] cnt_q    [4];
  logic [CntW-1:0] cnt_d    [4];

  logic [3:0]        empty;
  logic [3:0]        pop;
  logic [3:0]        push_ok;
  logic              grant_multi;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [1:0]        out_id_q,    out_id_d;
  logic              err_q,       err_d;

  // Occupancy decode, pop/push qualification and request generation.
  always_comb begin
    // A grant with more than one bit set is illegal and pops nothing anywhere.
    grant_multi = (grant & (grant - 4'd1)) != 4'd0;
    for (int i = 0; i < 4; i++) begin
      empty[i]   = (cnt_q[i] == '0);
      full[i]    = (cnt_q[i] == CntFull);
      pop[i]     = grant[i] & ~empty[i] & ~grant_multi;
      // A pop in the same edge frees a slot, so a push into a full FIFO is
      // still accepted then.
      push_ok[i] = push[i] & (~full[i] | pop[i]);
      // Withdraw the request while the last entry is being popped, so the
      // registered grant cannot land on an empty FIFO next cycle.
      req[i]     = cnt_q[i] > {{PtrW{1'b0}}, grant[i]};
    end
  end

  // Next-state for pointers and counts; pointers wrap modulo DEPTH for free.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push_ok[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
      unique case ({push_ok[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Output word selection and sticky error.
  always_comb begin
    out_valid_d = |pop;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    // pop is at most one-hot, so at most one iteration overrides the hold.
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        out_data_d = mem_q[i][rd_ptr_q[i]];
        out_id_d   = 2'(i);
      end
    end
    err_d = err_q | (|(grant & empty)) | grant_multi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: counts and pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wr_ptr_q[i]] <= push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err_grant = err_q;

`ifdef RRQ_STATS_EN
  logic [15:0] gcnt_q [4];
  logic [15:0] gcnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (stats_clr) begin
        gcnt_d[i] = '0;
      end else if (pop[i] && (gcnt_q[i] != 16'hFFFF)) begin
        gcnt_d[i] = gcnt_q[i] + 16'd1;
      end else begin
        gcnt_d[i] = gcnt_q[i];
      end
      grant_cnt[i*16 +: 16] = gcnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        gcnt_q[i] <= '0;
      end else begin
        gcnt_q[i] <= gcnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
// Testbench for rr_req_queue: directed scenarios followed by randomized
// push/grant traffic, checked each cycle against a queue-based reference model.
module tb_rr_req_queue;

  localparam int DW = 8;
  localparam int DP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      push;
  logic [4*DW-1:0] push_data;
  logic [3:0]      full;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            err_grant;
  logic            stats_clr;
`ifdef RRQ_STATS_EN
  logic [63:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  rr_req_queue #(
    .DATA_W(DW),
    .DEPTH (DP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .full     (full),
    .req      (req),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .err_grant(err_grant)
`ifdef RRQ_STATS_EN
    ,
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt)
`endif
  );

  // Reference model: one queue per client plus output/err/stat state.
  logic [DW-1:0] mq [4][$];
  logic          m_err;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_id;
  int unsigned   m_gcnt [4];
  bit            inited = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] model_req(input logic [3:0] g);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (int'(mq[i].size()) - (g[i] ? 1 : 0)) > 0;
    return r;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == DP);
    return f;
  endfunction

  function automatic logic [63:0] model_gcnt();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(m_gcnt[i]);
    return v;
  endfunction

  // One clock cycle: drive inputs away from the edge, check the combinational
  // outputs, advance the model at the edge, then check registered outputs.
  task automatic cycle(input logic [3:0] p, input logic [31:0] d, input logic [3:0] g,
                       input logic r, input logic sc);
    int npop;
    push = p; push_data = d; grant = g; reset = r; stats_clr = sc;
    #1;
    if (inited) begin
      chk("req", {60'd0, req}, {60'd0, model_req(g)});
      chk("full_pre", {60'd0, full}, {60'd0, model_full()});
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        m_gcnt[i] = 0;
      end
      m_err = 1'b0; m_valid = 1'b0; m_data = '0; m_id = '0;
      inited = 1'b1;
    end else begin
      npop = 0;
      if ($countones(g) > 1) m_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (g[i] && mq[i].size() == 0) m_err = 1'b1;
        if ($countones(g) == 1 && g[i] && mq[i].size() > 0) begin
          m_data = mq[i].pop_front();
          m_id   = 2'(i);
          npop++;
          if (m_gcnt[i] < 65535) m_gcnt[i]++;
        end
      end
      // The pop above already freed its slot, so push+pop on a full FIFO is accepted.
      for (int i = 0; i < 4; i++)
        if (p[i] && mq[i].size() < DP) mq[i].push_back(d[i*8 +: 8]);
      m_valid = (npop > 0);
      if (sc) for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_data", {56'd0, out_data}, {56'd0, m_data});
    chk("out_id", {62'd0, out_id}, {62'd0, m_id});
    chk("err_grant", {63'd0, err_grant}, {63'd0, m_err});
    chk("full_post", {60'd0, full}, {60'd0, model_full()});
`ifdef RRQ_STATS_EN
    chk("grant_cnt", grant_cnt, model_gcnt());
`endif
  endtask

  task automatic idle();
    cycle(4'd0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  g;
    logic [3:0]  p;
    logic [31:0] d;
    int          k;
    int          r;

    cycle(4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("rst_req", {60'd0, req}, 64'd0);

    // Single word A5 through client 0.
    cycle(4'b0001, 32'h0000_00A5, 4'd0, 1'b0, 1'b0);
    chk("a5_req_c1", {60'd0, req}, 64'h1);
    idle();
    cycle(4'd0, 32'd0, 4'b0001, 1'b0, 1'b0);
    chk("a5_valid", {63'd0, out_valid}, 64'd1);
    chk("a5_data", {56'd0, out_data}, 64'hA5);
    chk("a5_id", {62'd0, out_id}, 64'd0);
    idle();

    // Two words per client, rotation 0..3 twice.
    for (int n = 0; n < 2; n++)
      cycle(4'hF, {8'h30 + 8'(n), 8'h20 + 8'(n), 8'h10 + 8'(n), 8'(n)}, 4'd0, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) cycle(4'd0, 32'd0, 4'(1 << (n % 4)), 1'b0, 1'b0);
    idle();

    // Overflow client 2: last of DEPTH+1 pushes is dropped.
    for (int n = 0; n <= DP; n++) cycle(4'b0100, {8'd0, 8'h40 + 8'(n), 16'd0}, 4'd0, 1'b0, 1'b0);
    chk("ovf_full2", {63'd0, full[2]}, 64'd1);
    for (int n = 0; n < DP; n++) cycle(4'd0, 32'd0, 4'b0100, 1'b0, 1'b0);
    idle();

    // Client 1 full: push and grant together.
    for (int n = 0; n < DP; n++) cycle(4'b0010, {16'd0, 8'h50 + 8'(n), 8'd0}, 4'd0, 1'b0, 1'b0);
    cycle(4'b0010, {16'd0, 8'h5F, 8'd0}, 4'b0010, 1'b0, 1'b0);
    chk("pp_full1", {63'd0, full[1]}, 64'd1);
    for (int n = 0; n < DP; n++) cycle(4'd0, 32'd0, 4'b0010, 1'b0, 1'b0);
    idle();

    // Illegal grants: empty target, then multi-bit.
    cycle(4'd0, 32'd0, 4'b1000, 1'b0, 1'b0);
    chk("err_empty", {63'd0, err_grant}, 64'd1);
    chk("err_empty_nov", {63'd0, out_valid}, 64'd0);
    cycle(4'b0011, 32'h0000_6160, 4'd0, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 4'b0011, 1'b0, 1'b0);
    chk("err_multi_nov", {63'd0, out_valid}, 64'd0);
    idle();
    chk("err_sticky", {63'd0, err_grant}, 64'd1);
    cycle(4'd0, 32'd0, 4'b0001, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 4'b0010, 1'b0, 1'b0);

    // Reset with three words queued in client 0 and a grant in flight.
    for (int n = 0; n < 3; n++) cycle(4'b0001, 32'h70 + 32'(n), 4'd0, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 4'b0001, 1'b1, 1'b0);
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_req", {60'd0, req}, 64'd0);
    chk("rst_mid_full", {60'd0, full}, 64'd0);
`ifdef RRQ_STATS_EN
    chk("rst_mid_gcnt", grant_cnt, 64'd0);
`endif

    // Randomized traffic; legal grants target non-empty clients, with rare
    // illegal grants, stats clears and resets mixed in.
    for (int t = 0; t < 800; t++) begin
      p = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      d = $urandom();
      r = $urandom_range(0, 99);
      g = 4'd0;
      if (r < 3) begin
        g = 4'($urandom_range(0, 15));
      end else if (r < 65) begin
        k = $urandom_range(0, 3);
        if (mq[k].size() > 0) g = 4'(1 << k);
      end
      cycle(p, d, g, ($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_req_queue.md
Name: rr_req_queue

Overview:
Request front-end for the 4-way round-robin arbiter. Four clients push data words into private FIFOs. The block drives the arbiter's req[3:0] from FIFO occupancy and consumes the arbiter's registered grant[3:0]. On each grant it pops the granted FIFO and presents one word, tagged with its client ID, to the shared downstream resource.

Parameters:
DATA_W, 8, width of each client data word.
DEPTH, 4, entries per client FIFO; power of two, >=2.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
push  input  4  push[i] writes push_data[i] into FIFO i this cycle.
push_data  input  4*DATA_W  packed client data; client i occupies bits [i*DATA_W +: DATA_W].
full  output  4  full[i] = FIFO i holds DEPTH entries.
req  output  4  request vector to the arbiter.
grant  input  4  grant vector from the arbiter; registered, one-hot or zero.
out_valid  output  1  one-cycle pulse, one word delivered.
out_data  output  DATA_W  word popped from the granted FIFO.
out_id  output  2  client index of out_data.
err_grant  output  1  sticky error flag.

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: all FIFO counts and pointers 0, full=0, out_valid=0, out_data=0, out_id=0, err_grant=0. req is combinational and therefore reads 0 while counts are 0.
- FIFO storage: per client, DEPTH x DATA_W storage, with wr_ptr, rd_ptr and count[i] of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push:
  - Accepted when push[i]=1 and count[i]<DEPTH.
  - Push when full is dropped silently and does not set err_grant.
  - No data change and no pointer move on a dropped push.
- Pop:
  - pop[i] = grant[i] & (count[i]!=0).
  - out_valid, out_data and out_id are registered on the next rising edge: out_valid=1, out_data=mem[i][rd_ptr[i]], out_id=i. rd_ptr[i] and count[i] update on the same edge.
  - Latency from grant sampled to out_valid high is 1 cycle.
  - out_valid=0 in any cycle with no pop.
  - out_data and out_id hold their last value when out_valid=0.
- Request generation:
  - Combinational: req[i] = (count[i] - (grant[i] ? 1 : 0)) > 0, evaluated with count[i] != 0.
  - This withdraws the request in the cycle the last entry is being popped. Because the arbiter registers its grant, this prevents a grant on an empty FIFO.
  - Pushes become visible to req one cycle after the push edge.
- Simultaneous push and pop on the same FIFO:
  - count unchanged; both pointers advance.
  - Allowed when full: the pop frees a slot in the same edge, so the push is accepted.
- Error handling:
  - grant[i]=1 with count[i]==0, or grant with more than one bit set, sets err_grant=1 until reset.
  - The offending grant pops nothing.
  - With a multi-bit grant, no pop occurs on any FIFO.
- Reset mid-operation: all FIFO contents are discarded, no out_valid is produced in the reset cycle, and req drops in the same cycle because counts read 0.
- No backpressure on the output side: the downstream stage must accept every out_valid pulse.

Optional Feature:
- Macro RRQ_STATS_EN.
- When defined:
  - Adds output grant_cnt of width 4*16: per-client 16-bit saturating counters of successful pops.
  - Counters hold at 16'hFFFF and clear on reset.
  - Adds input stats_clr (1 bit), which zeroes all counters synchronously.
  - If stats_clr coincides with a pop, the clear wins.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push client 0 with 8'hA5 at cycle 0:
  - req=4'b0001 at cycle 1.
  - Grant 4'b0001 returned at cycle 2.
  - out_valid=1, out_data=8'hA5, out_id=0 at cycle 3.
  - req=0 during cycle 2, and no second grant follows.
- Fill all four FIFOs with 2 words each (client i data = 8'h10*i + n), then drive the arbiter rotation 0,1,2,3:
  - 8 out_valid pulses, with out_id sequence matching the grants.
  - Per-client data order preserved.
  - Never more than one pulse per cycle.
- Push client 2 DEPTH+1 times back-to-back with no grants:
  - full[2]=1 after DEPTH pushes.
  - The last word is dropped.
  - Draining yields exactly DEPTH words in order.
- Client 1 full; push[1] and grant[1] in the same cycle:
  - Count stays at DEPTH.
  - The pushed word is later output after the existing entries.
- Force grant=4'b1000 while FIFO 3 is empty, and separately grant=4'b0011:
  - err_grant=1 and stays sticky.
  - No out_valid pulse for either grant.
  - Counts unchanged.
- Assert reset with 3 words queued in client 0 and a grant in flight:
  - Next cycle: out_valid=0, req=0, full=0.
  - With RRQ_STATS_EN defined, grant_cnt=0.
